iic_slave_regif: RTL and testbench
==================================

IIC_SLAVE_REGIF -- requirements
Module: iic_slave_regif

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h10, the 7-bit device address this block responds to.
REQ-002 SHALL have port clock_in, input, 1 bit, the single system clock; all logic is synchronous to it except reset.
REQ-003 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port i2c_sck, input, 1 bit, bus clock; this block never drives it.
REQ-005 SHALL have port i2c_sda, inout, 1 bit, open-drain: driven 1'b0 or 1'bz only.
REQ-006 SHALL have port wr_en, output, 1 bit, one-cycle register-write strobe.
REQ-007 SHALL have port wr_addr, output, 16 bits, register address; valid while wr_en=1.
REQ-008 SHALL have port wr_data, output, 8 bits, write data; valid while wr_en=1.
REQ-009 SHALL have port rd_req, output, 1 bit, one-cycle read-request strobe.
REQ-010 SHALL have port rd_addr, output, 16 bits, register address; valid while rd_req=1.
REQ-011 SHALL have port rd_data, input, 8 bits, read data; sampled the cycle after rd_req.
REQ-012 SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-013 SHALL pass i2c_sck and i2c_sda through 2-FF synchronizers plus one history FF each; all edge detection uses the synchronized signals; clock_in >= 16x SCL frequency.
REQ-014 SHALL detect START as SDA high->low while SCL high, and STOP as SDA low->high while SCL high.
REQ-015 SHALL sample received bits, MSB first, on the SCL rising edge, and change its driven SDA only on the SCL falling edge.
REQ-016 SHALL implement the following FSM states: IDLE, DEV, ACK_DEV, REGH, ACK_REGH, REGL, ACK_REGL, WDATA, ACK_WDATA, RDATA, MACK, WAIT_STOP.
REQ-017 SHALL go to DEV on START from any state, including a repeated START mid-byte; the bit counter and shift register are cleared.
REQ-018 SHALL go to IDLE on STOP from any state, with SDA released the same cycle.
REQ-019 DEV: after 8 bits, if bits[7:1]==SLAVE_ADDR go to ACK_DEV, else go to WAIT_STOP with no ACK.
REQ-020 ACK_DEV/ACK_REGH/ACK_REGL/ACK_WDATA: drive SDA low from the falling edge after bit 8 until the next falling edge, then release.
REQ-021 After ACK_DEV: R/W=0 -> REGH; R/W=1 -> RDATA.
REQ-022 REGH then REGL load the 16-bit pointer (high byte first); after ACK_REGL -> WDATA.
REQ-023 On the 8th WDATA bit: pulse wr_en one cycle after the sampling edge with wr_addr=pointer and wr_data=byte, then enter ACK_WDATA.
REQ-024 After ACK_WDATA -> WDATA; the pointer increments by 1 after each wr_en and wraps 16'hFFFF -> 16'h0000.
REQ-025 RDATA entry: pulse rd_req with rd_addr=pointer on the SCL falling edge that ends the ACK slot.
REQ-026 RDATA: the next cycle, load rd_data into the shift register and drive bit 7 (0 -> SDA low, 1 -> release); drive the next bit on each subsequent falling edge.
REQ-027 RDATA: after 8 bits, release SDA, enter MACK, and increment the pointer (with wrap).
REQ-028 MACK: sample SDA on the SCL rising edge; 0 (ACK) -> RDATA with a new rd_req; 1 (NACK) -> WAIT_STOP.
REQ-029 WAIT_STOP: SDA released, no strobes; exits only on START or STOP.
REQ-030 The pointer SHALL persist across transactions until reset, so a write of REGH/REGL followed by STOP or repeated START sets the read address.
REQ-031 wr_en and rd_req SHALL never be asserted in the same cycle, and each SHALL be at most one cycle wide per byte.

Reset
REQ-032 While reset_n=0: FSM=IDLE, SDA released (z), wr_en=0, rd_req=0, busy=0, wr_addr=0, wr_data=0, rd_addr=0, pointer=0, synchronizers=1.
REQ-033 Reset asserted mid-transfer SHALL release SDA asynchronously; after release the block ignores the bus until the next START.

Verification
REQ-034 Write at 100 kHz, clock_in 50 MHz: START, 0x20, 0x30, 0x08, 0x82, STOP -> 4 ACKs; exactly one wr_en with wr_addr=16'h3008, wr_data=8'h82; busy falls at STOP.
REQ-035 Address mismatch: START, 0x6C, 0x30 -> SDA never driven low by the DUT, no wr_en, FSM in WAIT_STOP until STOP.
REQ-036 Burst write at 16'hFFFF with data 0xA1, 0xA2, 0xA3 -> wr_en three times with addresses FFFF, 0000, 0001.
REQ-037 Random read: write pointer 0x300A, Sr, 0x21, master ACK then NACK, rd_data=0xD8 then 0x5C -> rd_req at 300A then 300B; SDA bytes 0xD8, 0x5C; WAIT_STOP after the NACK.
REQ-038 Repeated START inside WDATA after 3 bits -> no wr_en, FSM returns to DEV; reset_n pulse during an ACK slot -> SDA goes z immediately and outputs match REQ-032.

Source files
------------

// File: rtl/iic_slave_regif.sv
// I2C slave front end for a 16-bit-addressed register file.
//
// The bus is decoded entirely in the clock_in domain. clock_in must be at
// least 16x the SCL rate.
//
// Write transaction: device address (R/W=0), pointer high byte, pointer low
// byte, then any number of data bytes. Each data byte produces one wr_en
// strobe, and the pointer advances after each strobe.
//
// Read transaction: after a device address with R/W=1, each byte produces one
// rd_req strobe for the current pointer. rd_data is taken one cycle after the
// strobe.
//
// The pointer survives STOP and repeated START, so a write that only sets the
// pointer selects the address for a following read.
//
// Ports:
//   clock_in        system clock
//   reset_n         asynchronous active-low reset
//   i2c_sck         bus clock (input only)
//   i2c_sda         open-drain bus data, driven 0 or z
//   wr_en           one-cycle write strobe, qualifies wr_addr/wr_data
//   wr_addr/wr_data write address/data
//   rd_req          one-cycle read strobe, qualifies rd_addr
//   rd_addr         read address
//   rd_data         read data returned by the register file
//   busy            high whenever the FSM is not idle
module iic_slave_regif #(
  parameter logic [6:0] SLAVE_ADDR = 7'h10
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        i2c_sck,
  inout  wire         i2c_sda,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, REGH, ACK_REGH, REGL, ACK_REGL,
    WDATA, ACK_WDATA, RDATA, MACK, WAIT_STOP
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  rx_byte;
  logic [15:0] pointer;
  logic        sda_low;
  logic        rw;
  logic        mack_ok;
  logic        load_pend;

  assign i2c_sda = sda_low ? 1'b0 : 1'bz;
  assign busy    = (state != IDLE);

  // Two synchronizer stages plus one history stage per bus line.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= i2c_sck;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= i2c_sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  always_comb begin
    scl_rise  = scl_s2 & ~scl_d;
    scl_fall  = ~scl_s2 & scl_d;
    start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    rx_byte   = {shift[6:0], sda_s2};
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      pointer   <= '0;
      sda_low   <= 1'b0;
      rw        <= 1'b0;
      mack_ok   <= 1'b0;
      load_pend <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
    end else begin
      wr_en     <= 1'b0;
      rd_req    <= 1'b0;
      load_pend <= rd_req;
      if (start_det) begin
        state   <= DEV;
        bit_cnt <= '0;
        shift   <= '0;
        sda_low <= 1'b0;
        mack_ok <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_low <= 1'b0;
        mack_ok <= 1'b0;
      end else begin
        case (state)
          DEV, REGH, REGL, WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              // 3-bit counter wraps to 0 on the 8th bit, ready for the next byte.
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (state)
                  DEV: begin
                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                      rw    <= rx_byte[0];
                      state <= ACK_DEV;
                    end else begin
                      state <= WAIT_STOP;
                    end
                  end
                  REGH: begin
                    pointer[15:8] <= rx_byte;
                    state         <= ACK_REGH;
                  end
                  REGL: begin
                    pointer[7:0] <= rx_byte;
                    state        <= ACK_REGL;
                  end
                  default: begin
                    wr_en   <= 1'b1;
                    wr_addr <= pointer;
                    wr_data <= rx_byte;
                    pointer <= pointer + 16'd1;
                    state   <= ACK_WDATA;
                  end
                endcase
              end
            end
          end

          // sda_low doubles as the phase flag: the first falling edge opens the
          // ACK slot, the second closes it.
          ACK_DEV, ACK_REGH, ACK_REGL, ACK_WDATA: begin
            if (scl_fall) begin
              if (!sda_low) begin
                sda_low <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                case (state)
                  ACK_DEV: begin
                    if (rw) begin
                      state   <= RDATA;
                      rd_req  <= 1'b1;
                      rd_addr <= pointer;
                    end else begin
                      state <= REGH;
                    end
                  end
                  ACK_REGH: state <= REGL;
                  default:  state <= WDATA;
                endcase
              end
            end
          end

          RDATA: begin
            if (load_pend) begin
              shift   <= rd_data;
              sda_low <= ~rd_data[7];
            end else if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_low <= 1'b0;
                bit_cnt <= '0;
                pointer <= pointer + 16'd1;
                mack_ok <= 1'b0;
                state   <= MACK;
              end else begin
                shift   <= {shift[6:0], 1'b0};
                sda_low <= ~shift[6];
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          // Master ACK is sampled on the rising edge, but the next byte starts
          // on the falling edge so SDA never moves while SCL is high.
          MACK: begin
            if (scl_rise) begin
              if (sda_s2) state   <= WAIT_STOP;
              else        mack_ok <= 1'b1;
            end else if (scl_fall && mack_ok) begin
              mack_ok <= 1'b0;
              rd_req  <= 1'b1;
              rd_addr <= pointer;
              state   <= RDATA;
            end
          end

          IDLE, WAIT_STOP: ;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_slave_regif.sv
module tb_iic_slave_regif;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  wire         sda;
  logic        wr_en, rd_req, busy;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data = 8'h00;

  int unsigned q = 8;
  int          total = 0;
  int          bad = 0;

  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, wide_cnt = 0;
  logic [15:0] wr_a [0:7];
  logic [7:0]  wr_d [0:7];
  logic [15:0] rd_a [0:7];
  logic        wr_en_q = 1'b0, rd_req_q = 1'b0;
  logic        dut_low_seen = 1'b0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  iic_slave_regif #(.SLAVE_ADDR(7'h10)) dut (
    .clock_in (clk),
    .reset_n  (rst_n),
    .i2c_sck  (scl),
    .i2c_sda  (sda),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // Bus monitor and register-file read model.
  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 8) begin
        wr_a[wr_cnt] = wr_addr;
        wr_d[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
    if (rd_req) begin
      if (rd_cnt < 8) rd_a[rd_cnt] = rd_addr;
      rd_cnt++;
      case (rd_addr)
        16'h300A: rd_data = 8'hD8;
        16'h300B: rd_data = 8'h5C;
        default:  rd_data = rd_addr[7:0] ^ 8'h3C;
      endcase
    end
    if (wr_en && rd_req) both_cnt++;
    if ((wr_en && wr_en_q) || (rd_req && rd_req_q)) wide_cnt++;
    wr_en_q = wr_en;
    rd_req_q = rd_req;
    if (!m_low && sda === 1'b0) dut_low_seen = 1'b1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_cnt = 0;
    rd_cnt = 0;
    dut_low_seen = 1'b0;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_clks(q);
    scl = 1'b1;   wait_clks(q);
    m_low = 1'b1; wait_clks(q);
    scl = 1'b0;   wait_clks(q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_clks(q);
    scl = 1'b1;   wait_clks(q);
    m_low = 1'b0; wait_clks(q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_low = ~b[i]; wait_clks(q);
      scl = 1'b1;    wait_clks(2 * q);
      scl = 1'b0;    wait_clks(q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    write_bits(b, 8);
    m_low = 1'b0; wait_clks(q);
    scl = 1'b1;   wait_clks(q);
    ack = (sda === 1'b0);
    wait_clks(q);
    scl = 1'b0;   wait_clks(q);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    b = '0;
    m_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_clks(q);
      scl = 1'b1; wait_clks(q);
      b = {b[6:0], (sda === 1'b0) ? 1'b0 : 1'b1};
      wait_clks(q);
      scl = 1'b0; wait_clks(q);
    end
    m_low = ~nack; wait_clks(q);
    scl = 1'b1;    wait_clks(2 * q);
    scl = 1'b0;    wait_clks(q);
    m_low = 1'b0;
  endtask

  task automatic test_reset();
    wait_clks(4);
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%0h want=0", busy); end
    total++; if (wr_en !== 1'b0)     begin bad++; $display("FAIL rst_wr_en got=%0h want=0", wr_en); end
    total++; if (rd_req !== 1'b0)    begin bad++; $display("FAIL rst_rd_req got=%0h want=0", rd_req); end
    total++; if (wr_addr !== 16'h0)  begin bad++; $display("FAIL rst_wr_addr got=%h want=0000", wr_addr); end
    total++; if (wr_data !== 8'h0)   begin bad++; $display("FAIL rst_wr_data got=%h want=00", wr_data); end
    total++; if (rd_addr !== 16'h0)  begin bad++; $display("FAIL rst_rd_addr got=%h want=0000", rd_addr); end
    total++; if (sda !== 1'b1)       begin bad++; $display("FAIL rst_sda got=%b want=1", sda); end
    rst_n = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_write_100k();
    logic a0, a1, a2, a3;
    q = 125;
    clear_log();
    i2c_start();
    write_byte(8'h20, a0);
    write_byte(8'h30, a1);
    write_byte(8'h08, a2);
    write_byte(8'h82, a3);
    total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL w100_acks got=%b want=1111", {a0, a1, a2, a3}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL w100_busy_before_stop got=%0h want=1", busy); end
    i2c_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL w100_busy_after_stop got=%0h want=0", busy); end
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL w100_wr_count got=%0d want=1", wr_cnt); end
    total++; if (wr_a[0] !== 16'h3008) begin bad++; $display("FAIL w100_wr_addr got=%h want=3008", wr_a[0]); end
    total++; if (wr_d[0] !== 8'h82) begin bad++; $display("FAIL w100_wr_data got=%h want=82", wr_d[0]); end
    q = 8;
    wait_clks(4 * q);
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    clear_log();
    i2c_start();
    write_byte(8'h6C, a0);
    write_byte(8'h30, a1);
    total++; if ({a0, a1} !== 2'b00) begin bad++; $display("FAIL mis_acks got=%b want=00", {a0, a1}); end
    total++; if (dut_low_seen !== 1'b0) begin bad++; $display("FAIL mis_sda_driven got=%b want=0", dut_low_seen); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mis_busy_wait_stop got=%0h want=1", busy); end
    i2c_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mis_busy_after_stop got=%0h want=0", busy); end
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL mis_wr_count got=%0d want=0", wr_cnt); end
    wait_clks(4 * q);
  endtask

  task automatic test_burst_wrap();
    logic [5:0] acks;
    logic a;
    logic [7:0] bytes [0:5];
    bytes[0] = 8'h20; bytes[1] = 8'hFF; bytes[2] = 8'hFF;
    bytes[3] = 8'hA1; bytes[4] = 8'hA2; bytes[5] = 8'hA3;
    clear_log();
    i2c_start();
    for (int i = 0; i < 6; i++) begin
      write_byte(bytes[i], a);
      acks[i] = a;
    end
    i2c_stop();
    total++; if (acks !== 6'h3F) begin bad++; $display("FAIL burst_acks got=%b want=111111", acks); end
    total++; if (wr_cnt !== 3) begin bad++; $display("FAIL burst_wr_count got=%0d want=3", wr_cnt); end
    total++; if (wr_a[0] !== 16'hFFFF) begin bad++; $display("FAIL burst_addr0 got=%h want=ffff", wr_a[0]); end
    total++; if (wr_a[1] !== 16'h0000) begin bad++; $display("FAIL burst_addr1 got=%h want=0000", wr_a[1]); end
    total++; if (wr_a[2] !== 16'h0001) begin bad++; $display("FAIL burst_addr2 got=%h want=0001", wr_a[2]); end
    total++; if ({wr_d[0], wr_d[1], wr_d[2]} !== 24'hA1A2A3) begin bad++; $display("FAIL burst_data got=%h want=a1a2a3", {wr_d[0], wr_d[1], wr_d[2]}); end
    wait_clks(4 * q);
  endtask

  task automatic test_random_read();
    logic a0, a1, a2, a3;
    logic [7:0] b0, b1, b2;
    clear_log();
    i2c_start();
    write_byte(8'h20, a0);
    write_byte(8'h30, a1);
    write_byte(8'h0A, a2);
    i2c_start();
    write_byte(8'h21, a3);
    total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL rd_acks got=%b want=1111", {a0, a1, a2, a3}); end
    read_byte(1'b0, b0);
    read_byte(1'b1, b1);
    total++; if (b0 !== 8'hD8) begin bad++; $display("FAIL rd_byte0 got=%h want=d8", b0); end
    total++; if (b1 !== 8'h5C) begin bad++; $display("FAIL rd_byte1 got=%h want=5c", b1); end
    total++; if (rd_cnt !== 2) begin bad++; $display("FAIL rd_req_count got=%0d want=2", rd_cnt); end
    total++; if (rd_a[0] !== 16'h300A) begin bad++; $display("FAIL rd_addr0 got=%h want=300a", rd_a[0]); end
    total++; if (rd_a[1] !== 16'h300B) begin bad++; $display("FAIL rd_addr1 got=%h want=300b", rd_a[1]); end
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL rd_wr_count got=%0d want=0", wr_cnt); end
    // After the NACK the slave must stay silent until STOP.
    dut_low_seen = 1'b0;
    read_byte(1'b1, b2);
    total++; if (b2 !== 8'hFF) begin bad++; $display("FAIL rd_wait_stop_bus got=%h want=ff", b2); end
    total++; if (dut_low_seen !== 1'b0) begin bad++; $display("FAIL rd_wait_stop_driven got=%b want=0", dut_low_seen); end
    total++; if (rd_cnt !== 2) begin bad++; $display("FAIL rd_wait_stop_req got=%0d want=2", rd_cnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_wait_stop_busy got=%0h want=1", busy); end
    i2c_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_after_stop got=%0h want=0", busy); end
    wait_clks(4 * q);
  endtask

  task automatic test_rstart_wdata();
    logic a0, a1, a2, a3, a4, a5, a6;
    clear_log();
    i2c_start();
    write_byte(8'h20, a0);
    write_byte(8'h12, a1);
    write_byte(8'h34, a2);
    write_bits(8'hA0, 3);
    i2c_start();
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL rs_no_write got=%0d want=0", wr_cnt); end
    write_byte(8'h20, a3);
    write_byte(8'h40, a4);
    write_byte(8'h00, a5);
    write_byte(8'h55, a6);
    i2c_stop();
    total++; if ({a0, a1, a2, a3, a4, a5, a6} !== 7'h7F) begin bad++; $display("FAIL rs_acks got=%b want=1111111", {a0, a1, a2, a3, a4, a5, a6}); end
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL rs_wr_count got=%0d want=1", wr_cnt); end
    total++; if (wr_a[0] !== 16'h4000) begin bad++; $display("FAIL rs_wr_addr got=%h want=4000", wr_a[0]); end
    total++; if (wr_d[0] !== 8'h55) begin bad++; $display("FAIL rs_wr_data got=%h want=55", wr_d[0]); end
    wait_clks(4 * q);
  endtask

  task automatic test_reset_in_ack();
    logic a0, a1;
    logic [7:0] b0;
    clear_log();
    i2c_start();
    write_bits(8'h20, 8);
    m_low = 1'b0;
    wait_clks(q);
    total++; if (sda !== 1'b0) begin bad++; $display("FAIL ra_ack_driven got=%b want=0", sda); end
    rst_n = 1'b0;
    #1;
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL ra_sda_async_release got=%b want=1", sda); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ra_busy got=%0h want=0", busy); end
    total++; if ({wr_en, rd_req} !== 2'b00) begin bad++; $display("FAIL ra_strobes got=%b want=00", {wr_en, rd_req}); end
    total++; if ({wr_addr, wr_data, rd_addr} !== 40'h0) begin bad++; $display("FAIL ra_regs got=%h want=0", {wr_addr, wr_data, rd_addr}); end
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    // Bus activity without START is ignored.
    write_byte(8'h20, a0);
    total++; if (a0 !== 1'b0) begin bad++; $display("FAIL ra_ignore_ack got=%b want=0", a0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ra_ignore_busy got=%0h want=0", busy); end
    // Pointer was cleared by reset: a read now targets 0000 (model returns 3c).
    i2c_start();
    write_byte(8'h21, a1);
    read_byte(1'b1, b0);
    i2c_stop();
    total++; if (a1 !== 1'b1) begin bad++; $display("FAIL ra_dev_ack got=%b want=1", a1); end
    total++; if (rd_a[0] !== 16'h0000) begin bad++; $display("FAIL ra_ptr_reset got=%h want=0000", rd_a[0]); end
    total++; if (b0 !== 8'h3C) begin bad++; $display("FAIL ra_rd_byte got=%h want=3c", b0); end
    wait_clks(4 * q);
  endtask

  initial begin
    test_reset();
    test_write_100k();
    test_addr_mismatch();
    test_burst_wrap();
    test_random_read();
    test_rstart_wdata();
    test_reset_in_ack();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", both_cnt); end
    total++; if (wide_cnt !== 0) begin bad++; $display("FAIL strobe_width got=%0d want=0", wide_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
